// File: rtl/key_pulse_gen_if.sv
// Port bundle for key_pulse_gen: event requests in, key waveform and queue status out.
// master drives the requests; slave is the pulse generator.
interface key_pulse_gen_if #(
    parameter int PEND_W = 4
);
    logic              trig;
    logic              ovf_clr;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              ovf;

    modport master (
        output trig, ovf_clr,
        input  out, busy, pending, ovf
    );

    modport slave (
        input  trig, ovf_clr,
        output out, busy, pending, ovf
    );
endinterface

// File: rtl/key_pulse_gen.sv
// Turns single-cycle trigger events into spaced, fixed-width key pulses, queueing events that overlap.
// Define KEY_PULSE_GEN_ACTIVE_LOW_EN to make the pulse active-low on `out`.
module key_pulse_gen #(
    parameter int HIGH_CYCLES = 16,
    parameter int GAP_CYCLES  = 16,
    parameter int PEND_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    key_pulse_gen_if.slave bus
);

    localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

`ifdef KEY_PULSE_GEN_ACTIVE_LOW_EN
    localparam logic OUT_IDLE = 1'b1;
`else
    localparam logic OUT_IDLE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              gap_done;

    assign gap_done = (state_q == GAP) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q & ~bus.ovf_clr;

        case (state_q)
            IDLE: begin
                if (bus.trig) begin
                    state_d = HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    // A trigger landing on the gap's last edge counts as pending work.
                    if ((pend_q != '0) || bus.trig) begin
                        state_d = HIGH;
                        cnt_d   = HIGH_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // On the dequeue edge a coincident trigger replaces the event leaving the queue.
        if (gap_done) begin
            if (!bus.trig && (pend_q != '0)) begin
                pend_d = pend_q - PEND_ONE;
            end
        end else if (bus.trig && (state_q != IDLE)) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end

        out_d  = (state_d == HIGH) ? ~OUT_IDLE : OUT_IDLE;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= OUT_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.pending = pend_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen; predicts each event's pulse start time from the scheduling rules.
// Honours KEY_PULSE_GEN_ACTIVE_LOW_EN by inverting the expected `out` level.
module tb_key_pulse_gen;

    localparam int H    = 4;
    localparam int G    = 3;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

`ifdef KEY_PULSE_GEN_ACTIVE_LOW_EN
    localparam logic LOW = 1'b1;
`else
    localparam logic LOW = 1'b0;
`endif

    logic clk;
    logic rst;

    key_pulse_gen_if #(.PEND_W(PW)) bus ();

    key_pulse_gen #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_W     (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int failed;
    int cyc;

    // Reference model: start edge of every accepted event still relevant.
    int          starts[$];
    int          d_last;
    logic        m_ovf;
    logic        exp_out;
    logic        exp_busy;
    logic [PW-1:0] exp_pend;
    logic [PW+2:0] exp_vec;

    logic act_prev;
    int   n_edges;
    int   n_act;
    int   n_busy;

    // Drive one cycle of inputs, advance the model for this edge, then sample after the edge.
    task automatic tick(input logic t, input logic c, input logic r);
        int queued;
        int s;
        int np;
        bus.trig    = t;
        bus.ovf_clr = c;
        rst         = r;
        if (r) begin
            starts.delete();
            d_last = -1000;
            m_ovf  = 1'b0;
        end else begin
            queued = 0;
            foreach (starts[i]) if (starts[i] > cyc) queued++;
            if (c) m_ovf = 1'b0;
            if (t) begin
                if (queued == PMAX) begin
                    m_ovf = 1'b1;
                end else begin
                    s = (cyc > d_last) ? cyc : d_last;
                    starts.push_back(s);
                    d_last = s + H + G;
                end
            end
        end
        while (starts.size() > 0 && starts[0] + H + G - 1 < cyc) void'(starts.pop_front());
        exp_out  = 1'b0;
        exp_busy = 1'b0;
        np       = 0;
        foreach (starts[i]) begin
            if (starts[i] <= cyc && cyc <= starts[i] + H - 1)     exp_out  = 1'b1;
            if (starts[i] <= cyc && cyc <= starts[i] + H + G - 1) exp_busy = 1'b1;
            if (starts[i] > cyc) np++;
        end
        exp_pend = PW'(np);
        exp_vec  = {exp_out ^ LOW, exp_busy, exp_pend, m_ovf};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        for (int i = 0; i < 60; i++) begin
            if (!exp_busy && exp_pend == '0) break;
            tick(1'b0, 1'b0, 1'b0);
        end
        act_prev = 1'b0;
        n_edges  = 0;
        n_act    = 0;
        n_busy   = 0;
    endtask

    task automatic track();
        logic act;
        act = bus.out ^ LOW;
        if (act && !act_prev) n_edges++;
        if (act) n_act++;
        if (bus.busy === 1'b1) n_busy++;
        act_prev = act;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tests++;
        if ({bus.out, bus.busy, bus.pending, bus.ovf} !== {LOW, 1'b0, 2'b00, 1'b0}) begin
            failed++;
            $display("[TB] FAIL reset_state got out/busy/pend/ovf=%b want %b",
                     {bus.out, bus.busy, bus.pending, bus.ovf}, {LOW, 1'b0, 2'b00, 1'b0});
        end
        tick(1'b0, 1'b0, 1'b0);
        tests++;
        if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
            failed++;
            $display("[TB] FAIL reset_idle cyc=%0d got %b want %b", cyc,
                     {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
        end
    endtask

    task automatic test_single_event();
        settle();
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 1'b0, 1'b0);
            track();
            tests++;
            if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
                failed++;
                $display("[TB] FAIL single_event cyc=%0d got %b want %b", cyc,
                         {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
            end
        end
        tests++;
        if (n_act != H || n_busy != H + G) begin
            failed++;
            $display("[TB] FAIL single_width got active=%0d busy=%0d want active=%0d busy=%0d",
                     n_act, n_busy, H, H + G);
        end
    endtask

    task automatic test_queueing();
        settle();
        for (int i = 0; i < 30; i++) begin
            tick(i == 0 || i == 2 || i == 3, 1'b0, 1'b0);
            track();
            tests++;
            if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
                failed++;
                $display("[TB] FAIL queueing cyc=%0d got %b want %b", cyc,
                         {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
            end
            if (i == 3 || i == 13 || i == 14) begin
                tests++;
                if (bus.pending !== ((i == 3) ? 2'd2 : (i == 13) ? 2'd1 : 2'd0)) begin
                    failed++;
                    $display("[TB] FAIL queue_depth step=%0d got %0d", i, bus.pending);
                end
            end
        end
        tests++;
        if (n_edges != 3) begin
            failed++;
            $display("[TB] FAIL queue_pulses got %0d want 3", n_edges);
        end
    endtask

    task automatic test_overflow();
        settle();
        for (int i = 0; i < 45; i++) begin
            tick(i < 6, 1'b0, 1'b0);
            track();
            tests++;
            if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
                failed++;
                $display("[TB] FAIL overflow cyc=%0d got %b want %b", cyc,
                         {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
            end
            if (i == 5) begin
                tests++;
                if (bus.pending !== 2'd3 || bus.ovf !== 1'b1) begin
                    failed++;
                    $display("[TB] FAIL ovf_saturate got pend=%0d ovf=%b want pend=3 ovf=1",
                             bus.pending, bus.ovf);
                end
            end
        end
        tests++;
        if (n_edges != 4) begin
            failed++;
            $display("[TB] FAIL ovf_pulses got %0d want 4", n_edges);
        end
        tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (bus.ovf !== 1'b0) begin
            failed++;
            $display("[TB] FAIL ovf_clear got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_simultaneous();
        settle();
        for (int i = 0; i < 22; i++) begin
            tick(i == 0 || i == 2 || i == H + G, 1'b0, 1'b0);
            tests++;
            if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
                failed++;
                $display("[TB] FAIL simultaneous cyc=%0d got %b want %b", cyc,
                         {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
            end
            if (i == H + G) begin
                tests++;
                if (bus.pending !== 2'd1 || bus.ovf !== 1'b0 || bus.out !== ~LOW) begin
                    failed++;
                    $display("[TB] FAIL trig_on_dequeue got pend=%0d ovf=%b out=%b want pend=1 ovf=0 out=%b",
                             bus.pending, bus.ovf, bus.out, ~LOW);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        settle();
        for (int i = 0; i < 25; i++) begin
            tick(i < 3, 1'b0, i == 4);
            if (i > 4) track();
            tests++;
            if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
                failed++;
                $display("[TB] FAIL reset_mid cyc=%0d got %b want %b", cyc,
                         {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
            end
            if (i == 4) begin
                tests++;
                if ({bus.out, bus.busy, bus.pending, bus.ovf} !== {LOW, 1'b0, 2'b00, 1'b0}) begin
                    failed++;
                    $display("[TB] FAIL reset_abort got %b want %b",
                             {bus.out, bus.busy, bus.pending, bus.ovf}, {LOW, 1'b0, 2'b00, 1'b0});
                end
            end
        end
        tests++;
        if (n_busy != 0 || n_edges != 0) begin
            failed++;
            $display("[TB] FAIL reset_no_restart got busy_cycles=%0d pulses=%0d want 0 0", n_busy, n_edges);
        end
    endtask

    task automatic test_random();
        logic t;
        logic c;
        logic r;
        for (int i = 0; i < 800; i++) begin
            t = ($urandom_range(0, 99) < 35);
            c = ($urandom_range(0, 99) < 5);
            r = ($urandom_range(0, 199) == 0);
            tick(t, c, r);
            tests++;
            if ({bus.out, bus.busy, bus.pending, bus.ovf} !== exp_vec) begin
                failed++;
                $display("[TB] FAIL random cyc=%0d got %b want %b", cyc,
                         {bus.out, bus.busy, bus.pending, bus.ovf}, exp_vec);
            end
        end
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        cyc         = 0;
        d_last      = -1000;
        m_ovf       = 1'b0;
        exp_out     = 1'b0;
        exp_busy    = 1'b0;
        exp_pend    = '0;
        exp_vec     = '0;
        rst         = 1'b1;
        bus.trig    = 1'b0;
        bus.ovf_clr = 1'b0;

        test_reset();
        test_single_event();
        test_queueing();
        test_overflow();
        test_simultaneous();
        test_reset_mid_pulse();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Converts single-cycle event pulses into clean, spaced, level-shaped key waveforms on one output pin.
- Transmit-side counterpart of the rising-edge key detector: every accepted trigger yields exactly one low-to-high transition on `out`.
- Drives LEDs, test outputs, or a downstream edge detector.
- Triggers that arrive during a pulse are queued, not merged.

Parameters:
- HIGH_CYCLES, 16, cycles `out` is held active per event; must be >= 1.
- GAP_CYCLES, 16, minimum inactive cycles after each pulse; must be >= 1.
- PEND_W, 4, width of the pending-event counter; the queue holds up to 2^PEND_W-1 events.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- trig  input  1  event request; each high cycle is one event.
- ovf_clr  input  1  clears the sticky overflow flag.
- out  output  1  generated key waveform (active-high by default).
- busy  output  1  high whenever state != IDLE.
- pending  output  PEND_W  number of queued events not yet started.
- ovf  output  1  sticky flag: an event was dropped because the queue was full.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, pending=0, ovf=0, out inactive (0), busy=0. Reset has priority over all inputs and aborts any pulse or gap in progress; the queue is discarded.
- States and transitions:
  - IDLE: on trig -> HIGH; counter loads HIGH_CYCLES-1.
  - HIGH: counter decrements each cycle. At counter=0 -> GAP; counter loads GAP_CYCLES-1.
  - GAP: counter decrements each cycle. At counter=0: if the effective pending count is > 0 -> HIGH, pending decremented, counter loads HIGH_CYCLES-1; otherwise -> IDLE.
- Counter width: clog2(max(HIGH_CYCLES, GAP_CYCLES)), minimum 1 bit.
- Outputs `out` and `busy` are registered decodes of the next state:
  - trig high at edge N while IDLE -> out=1 from cycle N+1 for exactly HIGH_CYCLES cycles.
  - out=0 for at least GAP_CYCLES cycles after each pulse.
- Queue rules:
  - pending is always 0 in IDLE.
  - trig in IDLE starts a pulse directly; pending is not touched.
  - trig in HIGH or GAP: pending+1.
  - trig on the same edge as the GAP->HIGH dequeue: pending unchanged (+1 and -1 net to zero); this is not an overflow.
  - trig while pending = 2^PEND_W-1 and no dequeue on that edge: the event is dropped, pending holds, ovf set to 1.
- ovf:
  - Cleared by ovf_clr=1 or by reset.
  - If ovf_clr and a new drop occur on the same edge, ovf ends at 1 (set wins).
- trig held high for K cycles = K events, subject to the queue limit; the block performs no edge detection on trig.
- Back-to-back queued events: GAP ends -> HIGH begins on the next cycle. Inactive time between pulses is exactly GAP_CYCLES.
- Every accepted event produces exactly one rising edge on `out`.

Optional Feature:
- Macro: KEY_PULSE_GEN_ACTIVE_LOW_EN.
- Defined:
  - `out` is inverted: idle/gap/reset level is 1, the pulse is 0.
  - Every other port and all timing are unchanged.
  - Each event produces exactly one falling edge.
- Undefined: active-high as described above.

Test Plan:
- Single event (HIGH_CYCLES=4, GAP_CYCLES=3): reset, then trig 1 cycle at edge 10 -> out=1 at cycles 11-14, out=0 from 15; busy=1 for cycles 11-17; busy=0 at 18; pending stays 0.
- Queueing (HIGH=4, GAP=3): trig at edges 10, 12, 13 -> pending goes 1 then 2. Out pulses at 11-14, 18-21 and 25-28, each separated by exactly 3 low cycles. pending=0 after edge 24.
- Overflow (PEND_W=2, HIGH=4, GAP=3): trig held high 6 cycles from IDLE -> 1 pulse starts, pending saturates at 3, 2 events dropped, ovf=1. A total of 4 pulses are emitted. Asserting ovf_clr for 1 cycle -> ovf=0.
- Simultaneous trig and dequeue: trig on the exact edge GAP ends with pending=1 -> pending stays 1, the next pulse starts, ovf stays 0.
- Reset mid-pulse: rst=1 during HIGH with pending=2 -> next cycle out=0, busy=0, pending=0, ovf=0; no further pulses without a new trig.
- With KEY_PULSE_GEN_ACTIVE_LOW_EN defined: repeat the single-event scenario -> out=1 at reset and idle, out=0 at cycles 11-14, out=1 from 15.
